// File: rtl/ascon_permutation_iter_pkg.sv
// -----------------------------------------------------------------------------
// ascon_permutation_iter_pkg
// Shared types and helpers for the iterative Ascon permutation core.
//   type_state   : five 64-bit words S0..S4 (S0 maps to the top 64 bits of the
//                  flat 320-bit state ports)
//   ROUNDS_A     : round count of p^a
//   perm_state_t : controller states IDLE / RUN / DONE
//   SBOX         : 5-bit Ascon S-box, index = {S0,S1,S2,S3,S4} column bits
//   round_const  : constant added to S2[7:0] in round i
//   rotr64       : 64-bit rotate right by a constant amount
// -----------------------------------------------------------------------------
package ascon_permutation_iter_pkg;

    localparam int ROUNDS_A = 12;

    typedef logic [63:0] type_state [5];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } perm_state_t;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // Rounds 0..11 give 0xF0, 0xE1, ..., 0x4B.
    function automatic logic [7:0] round_const(input logic [3:0] i);
        return {4'hF - i, i};
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_permutation_iter_round.sv
// -----------------------------------------------------------------------------
// ascon_permutation_iter_round
// One purely combinational Ascon round: constant addition, bitsliced 5-bit
// substitution, per-row linear diffusion.
//   state_i  in  type_state  state entering the round
//   round_i  in  4           round index 0..11 (selects the constant)
//   state_o  out type_state  state leaving the round
// -----------------------------------------------------------------------------
module ascon_permutation_iter_round
    import ascon_permutation_iter_pkg::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    // Each of the 64 columns is one 5-bit S-box input, S0 being the MSB.
    function automatic type_state substitute(input type_state s);
        type_state  t;
        logic [4:0] col;
        logic [4:0] sb;
        t = s;
        for (int c = 0; c < 64; c++) begin
            col     = {s[0][c], s[1][c], s[2][c], s[3][c], s[4][c]};
            sb      = SBOX[col];
            t[0][c] = sb[4];
            t[1][c] = sb[3];
            t[2][c] = sb[2];
            t[3][c] = sb[1];
            t[4][c] = sb[0];
        end
        return t;
    endfunction

    function automatic type_state diffuse(input type_state s);
        type_state t;
        t[0] = s[0] ^ rotr64(s[0], 19) ^ rotr64(s[0], 28);
        t[1] = s[1] ^ rotr64(s[1], 61) ^ rotr64(s[1], 39);
        t[2] = s[2] ^ rotr64(s[2], 1)  ^ rotr64(s[2], 6);
        t[3] = s[3] ^ rotr64(s[3], 10) ^ rotr64(s[3], 17);
        t[4] = s[4] ^ rotr64(s[4], 7)  ^ rotr64(s[4], 41);
        return t;
    endfunction

    type_state w_ca;
    type_state w_sb;

    always_comb begin
        w_ca          = state_i;
        w_ca[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
    end

    assign w_sb    = substitute(w_ca);
    assign state_o = diffuse(w_sb);

endmodule

// File: rtl/ascon_permutation_iter.sv
// -----------------------------------------------------------------------------
// ascon_permutation_iter
// Iterative Ascon permutation: p^a (12 rounds) or p^b (ROUNDS_B rounds) on a
// 320-bit state, UNROLL rounds per clock. Latency start->done is
// N/UNROLL + 1 cycles; the load cycle applies no round.
// Parameters: UNROLL (1,2,3,6), ROUNDS_B (6 or 8; 8 needs UNROLL 1 or 2).
// Ports:
//   clock_i   in  1    rising-edge clock
//   reset_i   in  1    asynchronous active-high reset
//   start_i   in  1    launch, honoured only while ready_o=1
//   mode_i    in  1    0: p^a, 1: p^b (sampled with start_i)
//   state_i   in  320  {S0,S1,S2,S3,S4} (sampled with start_i)
//   ready_o   out 1    idle and accepting start_i
//   done_o    out 1    one-cycle pulse, state_o holds the result
//   state_o   out 320  working/result register
//   round_o   out 4    r in RUN, 12 in DONE, 0 in IDLE
// Optional macro ASCON_PERM_KEYXOR_EN adds key_i (128) and keyxor_i (1); when
// keyxor_i was set at start, the last round also XORs key_i into S3:S4.
// -----------------------------------------------------------------------------
module ascon_permutation_iter
    import ascon_permutation_iter_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int ROUNDS_B = 6
)
(
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [319:0] state_i,
`ifdef ASCON_PERM_KEYXOR_EN
    input  logic [127:0] key_i,
    input  logic         keyxor_i,
`endif
    output logic         ready_o,
    output logic         done_o,
    output logic [319:0] state_o,
    output logic [3:0]   round_o
);

    generate
        if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6) ||
            !(ROUNDS_B == 6 || ROUNDS_B == 8) || (ROUNDS_B % UNROLL) != 0) begin : g_bad_cfg
            $error("ascon_permutation_iter: illegal UNROLL/ROUNDS_B combination");
        end
    endgenerate

    localparam logic [3:0] LP_STEP = 4'(UNROLL);
    localparam logic [3:0] LP_LAST = 4'(ROUNDS_A);
    localparam logic [3:0] LP_R0_B = 4'(ROUNDS_A - ROUNDS_B);

    perm_state_t r_fsm;
    perm_state_t w_fsm_nxt;
    type_state   r_state;
    logic [3:0]  r_round;
    type_state   w_state_in;
    type_state   w_state_run;
    type_state   w_chain [UNROLL+1];
    logic [3:0]  w_round_nxt;
    logic        w_last;
    logic        w_accept;

    assign w_accept    = (r_fsm == IDLE) && start_i;
    assign w_round_nxt = r_round + LP_STEP;
    assign w_last      = (w_round_nxt == LP_LAST);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            w_state_in[i] = state_i[319 - 64*i -: 64];
        end
    end

    // Round chain: instance k runs round r+k within the same clock.
    assign w_chain[0] = r_state;
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_permutation_iter_round u_round (
            .state_i (w_chain[k]),
            .round_i (r_round + 4'(k)),
            .state_o (w_chain[k+1])
        );
    end

`ifdef ASCON_PERM_KEYXOR_EN
    logic         r_keyxor;
    logic [127:0] r_key;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_keyxor <= 1'b0;
        end else if (w_accept) begin
            r_keyxor <= keyxor_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_accept) begin
            r_key <= key_i;
        end
    end

    // Key folds into the final round's result so latency is unchanged.
    always_comb begin
        w_state_run = w_chain[UNROLL];
        if (w_last && r_keyxor) begin
            w_state_run[3] = w_chain[UNROLL][3] ^ r_key[127:64];
            w_state_run[4] = w_chain[UNROLL][4] ^ r_key[63:0];
        end
    end
`else
    assign w_state_run = w_chain[UNROLL];
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= '{default: '0};
            r_round <= 4'd0;
        end else if (w_accept) begin
            r_state <= w_state_in;
            r_round <= mode_i ? LP_R0_B : 4'd0;
        end else if (r_fsm == RUN) begin
            r_state <= w_state_run;
            r_round <= w_round_nxt;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        case (r_fsm)
            IDLE:    if (start_i) w_fsm_nxt = RUN;
            RUN:     if (w_last)  w_fsm_nxt = DONE;
            DONE:    w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // ready_o is masked by reset_i so it stays low while reset is held.
    always_comb begin
        ready_o = 1'b0;
        done_o  = 1'b0;
        round_o = 4'd0;
        case (r_fsm)
            IDLE:    ready_o = !reset_i;
            RUN:     round_o = r_round;
            DONE: begin
                done_o  = 1'b1;
                round_o = LP_LAST;
            end
            default: ;
        endcase
    end

    assign state_o = {r_state[0], r_state[1], r_state[2], r_state[3], r_state[4]};

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// -----------------------------------------------------------------------------
// tb_ascon_permutation_iter
// Drives an UNROLL=1 and an UNROLL=3 instance of ascon_permutation_iter side
// by side. Expected states come from a bitsliced reference permutation written
// in the style of the Ascon C reference; latencies are hand-derived.
// With ASCON_PERM_KEYXOR_EN defined the key-XOR option is exercised as well.
// -----------------------------------------------------------------------------
module tb_ascon_permutation_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic [319:0] state_in = '0;
    logic         ready1, done1, ready3, done3;
    logic [319:0] st1, st3;
    logic [3:0]   round1, round3;
`ifdef ASCON_PERM_KEYXOR_EN
    logic [127:0] key = '0;
    logic         keyxor = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ascon_permutation_iter #(.UNROLL(1), .ROUNDS_B(6)) u_dut1 (
        .clock_i (clk),
        .reset_i (rst),
        .start_i (start),
        .mode_i  (mode),
        .state_i (state_in),
`ifdef ASCON_PERM_KEYXOR_EN
        .key_i    (key),
        .keyxor_i (keyxor),
`endif
        .ready_o (ready1),
        .done_o  (done1),
        .state_o (st1),
        .round_o (round1)
    );

    ascon_permutation_iter #(.UNROLL(3), .ROUNDS_B(6)) u_dut3 (
        .clock_i (clk),
        .reset_i (rst),
        .start_i (start),
        .mode_i  (mode),
        .state_i (state_in),
`ifdef ASCON_PERM_KEYXOR_EN
        .key_i    (key),
        .keyxor_i (keyxor),
`endif
        .ready_o (ready3),
        .done_o  (done3),
        .state_o (st3),
        .round_o (round3)
    );

    function automatic logic [319:0] ref_perm(input logic [319:0] s, input int first);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int i = first; i < 12; i++) begin
            x2 = x2 ^ 64'(((15 - i) << 4) | i);
            x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
            x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
            x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
            x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
            x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
            x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
            x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch on both instances, record each done latency and the state then.
    task automatic run_txn(input logic md, input logic [319:0] st,
                           output int l1, output int l3,
                           output logic [319:0] o1, output logic [319:0] o3);
        mode = md; state_in = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~md; state_in = ~st;
        l1 = 0; l3 = 0; o1 = '0; o3 = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done1 && l1 == 0) begin l1 = c; o1 = st1; end
            if (done3 && l3 == 0) begin l3 = c; o3 = st3; end
            if (l1 != 0 && l3 != 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic         md;
        logic [319:0] st;
        int           lat1;
        int           lat3;
    } vec_t;

    localparam logic [319:0] KAT = {64'h80400c0600000000, 64'h0001020304050607,
                                    64'h08090a0b0c0d0e0f, 64'h0, 64'h0};

    initial begin
        vec_t         vecs [5];
        int           l1, l3, nd1, nd3, nr1, nr3, cnt;
        logic [319:0] o1, o3, exp;
        logic         hit;

        vecs[0] = '{1'b0, KAT, 13, 5};
        vecs[1] = '{1'b1, KAT, 7, 3};
        vecs[2] = '{1'b0, 320'h0, 13, 5};
        vecs[3] = '{1'b1, {320{1'b1}}, 7, 3};
        vecs[4] = '{1'b0, {5{64'h0123456789abcdef}} ^ {64'h0, 64'hff, 64'h0, 64'hf0f0, 64'h1}, 13, 5};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_ready1", 320'(ready1), 320'(0));
        chk("rst_ready3", 320'(ready3), 320'(0));
        chk("rst_done1",  320'(done1),  320'(0));
        chk("rst_state1", st1, 320'h0);
        chk("rst_round1", 320'(round1), 320'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rel_ready1", 320'(ready1), 320'(1));
        chk("rel_ready3", 320'(ready3), 320'(1));
        chk("rel_done1",  320'(done1),  320'(0));
        @(posedge clk); #1;

        // Vector table
        for (int v = 0; v < 5; v++) begin
            exp = ref_perm(vecs[v].st, vecs[v].md ? 6 : 0);
            run_txn(vecs[v].md, vecs[v].st, l1, l3, o1, o3);
            chk($sformatf("v%0d_lat_u1", v), 320'(l1), 320'(vecs[v].lat1));
            chk($sformatf("v%0d_lat_u3", v), 320'(l3), 320'(vecs[v].lat3));
            chk($sformatf("v%0d_state_u1", v), o1, exp);
            chk($sformatf("v%0d_state_u3", v), o3, exp);
            chk($sformatf("v%0d_held_u1", v), st1, exp);
            chk($sformatf("v%0d_ready_u1", v), 320'(ready1), 320'(1));
        end

        // p^b round index trace on the UNROLL=1 instance
        mode = 1'b1; state_in = KAT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("pb_round_c%0d", c), 320'(round1), 320'(5 + c));
            chk($sformatf("pb_busy_c%0d", c), 320'({ready1, done1}), 320'(0));
            @(posedge clk); #1;
        end
        chk("pb_done_c7",  320'(done1),  320'(1));
        chk("pb_round_c7", 320'(round1), 320'(12));
        @(posedge clk); #1;
        chk("pb_idle_done",  320'(done1),  320'(0));
        chk("pb_idle_round", 320'(round1), 320'(0));
        chk("pb_idle_ready", 320'(ready1), 320'(1));
        @(posedge clk); #1;

        // start held high: back-to-back accepts, one done per accept
        mode = 1'b0; state_in = KAT; start = 1'b1;
        nd1 = 0; nd3 = 0; nr1 = 0; nr3 = 0; o1 = '0;
        exp = ref_perm(KAT, 0);
        for (int e = 0; e <= 26; e++) begin
            @(posedge clk); #1;
            if (done1) begin nd1++; o1 = st1; end
            if (done3) nd3++;
            if (ready1) nr1++;
            if (ready3) nr3++;
        end
        start = 1'b0;
        chk("hold_dones_u1", 320'(nd1), 320'(2));
        chk("hold_dones_u3", 320'(nd3), 320'(4));
        chk("hold_ready_u1", 320'(nr1), 320'(1));
        chk("hold_ready_u3", 320'(nr3), 320'(4));
        chk("hold_state_u1", o1, exp);
        cnt = 0;
        while (!(ready1 && ready3) && cnt < 40) begin
            @(posedge clk); #1; cnt++;
        end
        chk("hold_drain", 320'(ready1 && ready3), 320'(1));

        // Async reset mid p^a
        mode = 1'b0; state_in = KAT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (round1 == 4'd5) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("abort_reach_r5", 320'(hit), 320'(1));
        rst = 1'b1;
        #1;
        chk("abort_state_u1", st1, 320'h0);
        chk("abort_state_u3", st3, 320'h0);
        chk("abort_round_u1", 320'(round1), 320'(0));
        chk("abort_ready_u1", 320'(ready1), 320'(0));
        nd1 = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done1 || done3) nd1++;
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready_after", 320'(ready1), 320'(1));
        repeat (15) begin
            @(posedge clk); #1;
            if (done1 || done3) nd1++;
        end
        chk("abort_no_done", 320'(nd1), 320'(0));
        chk("abort_state_kept0", st1, 320'h0);

`ifdef ASCON_PERM_KEYXOR_EN
        key = 128'h000102030405060708090a0b0c0d0e0f;
        keyxor = 1'b1;
        exp = ref_perm(KAT, 0) ^ {192'h0, key};
        run_txn(1'b0, KAT, l1, l3, o1, o3);
        chk("kx_lat_u1",   320'(l1), 320'(13));
        chk("kx_state_u1", o1, exp);
        chk("kx_state_u3", o3, exp);
        keyxor = 1'b0;
        exp = ref_perm(KAT, 0);
        run_txn(1'b0, KAT, l1, l3, o1, o3);
        chk("nokx_state_u1", o1, exp);
        chk("nokx_state_u3", o3, exp);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
